// File: rtl/unified_mem_pkg.sv
// Shared types and constants for the unified memory responder.
package unified_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_t;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
    localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/mem_word_array.sv
// Word storage with one synchronous bus read/write port and one preload write port.
module mem_word_array
    import unified_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_en_i,
    input  logic          bus_we_i,
    input  logic [AW-1:0] bus_idx_i,
    input  logic [31:0]   bus_wdata_i,
    output logic [31:0]   bus_rdata_o,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_idx_i,
    input  logic [31:0]   load_data_i
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Later assignment wins on the same word, so the bus store overrides the preload.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem_q[load_idx_i] <= load_data_i;
        end
        if (bus_en_i && bus_we_i) begin
            mem_q[bus_idx_i] <= bus_wdata_i;
        end
    end

    // Read data is present for exactly the cycle after the read commits, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= ERR_RDATA;
        end else if (bus_en_i && !bus_we_i) begin
            rdata_q <= mem_q[bus_idx_i];
        end else begin
            rdata_q <= ERR_RDATA;
        end
    end

    assign bus_rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// Req/ack memory target: one request at a time, programmable latency, single-cycle ack,
// side-band preload and saturating good-access counters.
module unified_mem_responder
    import unified_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS),
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic          mem_req,
    input  logic          mem_we,
    output logic [31:0]   mem_rdata,
    output logic          mem_ack,
    output logic          mem_err,
    output logic          busy,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);

    localparam logic [3:0]  LAT_INIT   = 4'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    mem_state_t    state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic          good_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          ack_q;
    logic          err_q;
    logic [15:0]   rd_count_q;
    logic [15:0]   wr_count_q;

    logic addr_good;
    logic commit;

    // BASE_ADDR is aligned to the array size, so the low address bits are the word index.
    assign addr_good = ((mem_addr & ALIGN_MASK) == 32'h0)
                    && ({1'b0, mem_addr} >= {1'b0, BASE_ADDR})
                    && ({1'b0, mem_addr} < ADDR_LIMIT);

    assign commit = (state_q == ACCESS) && (cnt_q == 4'd0) && good_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            good_q     <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_count_q <= 16'h0;
            wr_count_q <= 16'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        we_q    <= mem_we;
                        wdata_q <= mem_wdata;
                        idx_q   <= mem_addr[AW+1:2];
                        good_q  <= addr_good;
                        cnt_q   <= LAT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ack_q   <= 1'b1;
                        err_q   <= !good_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                    if (good_q && we_q && (wr_count_q != 16'hFFFF)) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end
                    if (good_q && !we_q && (rd_count_q != 16'hFFFF)) begin
                        rd_count_q <= rd_count_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_en_i   (commit),
        .bus_we_i   (we_q),
        .bus_idx_i  (idx_q),
        .bus_wdata_i(wdata_q),
        .bus_rdata_o(mem_rdata),
        .load_we_i  (load_we),
        .load_idx_i (load_addr),
        .load_data_i(load_data)
    );

    assign mem_ack  = ack_q;
    assign mem_err  = err_q;
    assign busy     = (state_q != IDLE);
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: a LATENCY=1 and a LATENCY=4 responder sharing clock, reset and preload port.
module tb_unified_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_req;
    logic        bus_we;
    logic        use4;
    logic        load_we;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, err1, err4, busy1, busy4;
    logic [15:0] rd1, rd4, wr1, wr4;

    logic [31:0] rdata_s;
    logic        ack_s, err_s;

    int checks = 0;
    int errors = 0;

    assign rdata_s = use4 ? rdata4 : rdata1;
    assign ack_s   = use4 ? ack4 : ack1;
    assign err_s   = use4 ? err4 : err1;

    unified_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (bus_addr),
        .mem_wdata(bus_wdata),
        .mem_req  (bus_req && !use4),
        .mem_we   (bus_we),
        .mem_rdata(rdata1),
        .mem_ack  (ack1),
        .mem_err  (err1),
        .busy     (busy1),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .rd_count (rd1),
        .wr_count (wr1)
    );

    unified_mem_responder #(.LATENCY(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (bus_addr),
        .mem_wdata(bus_wdata),
        .mem_req  (bus_req && use4),
        .mem_we   (bus_we),
        .mem_rdata(rdata4),
        .mem_ack  (ack4),
        .mem_err  (err4),
        .busy     (busy4),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .rd_count (rd4),
        .wr_count (wr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus_req = 1'b0;
        load_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] data);
        @(posedge clk);
        #1;
        load_we   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(posedge clk);
        #1;
        load_we = 1'b0;
    endtask

    // Drives one request; lat counts negedges after req rises until ack (-1 on timeout).
    task automatic bus_txn(input logic sel4, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic toggle, input logic coll,
                           input logic [11:0] coll_idx, input logic [31:0] coll_data,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic dbl);
        use4 = sel4;
        @(posedge clk);
        #1;
        bus_addr  = addr;
        bus_we    = we;
        bus_wdata = wdata;
        bus_req   = 1'b1;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 2) load_we = 1'b0;
            if (ack_s) begin
                lat   = n;
                rdata = rdata_s;
                err   = err_s;
                break;
            end
            if (n == 1 && coll) begin
                load_we   = 1'b1;
                load_addr = coll_idx;
                load_data = coll_data;
            end
            if (n == 1 && toggle) begin
                bus_addr  = addr ^ 32'h0000_003C;
                bus_we    = ~we;
                bus_wdata = ~wdata;
            end
        end
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        load_we = 1'b0;
        @(negedge clk);
        dbl = ack_s;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ack1, err1, busy1, rdata1, rd1, wr1} !== 67'h0) begin
            errors++;
            $display("FAIL reset_dut1: got ack=%b err=%b busy=%b rdata=%h rd=%0d wr=%0d, want all 0",
                     ack1, err1, busy1, rdata1, rd1, wr1);
        end
        checks++;
        if ({ack4, err4, busy4, rdata4, rd4, wr4} !== 67'h0) begin
            errors++;
            $display("FAIL reset_dut4: got ack=%b err=%b busy=%b rdata=%h rd=%0d wr=%0d, want all 0",
                     ack4, err4, busy4, rdata4, rd4, wr4);
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] rd; logic er; int lat; logic dbl;
        preload(12'd0, 32'h0010_0093);
        bus_txn(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL read_latency: got %0d want 2", lat);
        end
        checks++;
        if (rd !== 32'h0010_0093 || er !== 1'b0) begin
            errors++; $display("FAIL read_data: got %h err=%b want 00100093 err=0", rd, er);
        end
        checks++;
        if (dbl !== 1'b0 || rd1 !== 16'd1) begin
            errors++; $display("FAIL read_ack_count: got dbl=%b rd=%0d want 0 1", dbl, rd1);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; logic dbl;
        apply_reset();
        bus_txn(1'b0, 32'h40, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || dbl !== 1'b0) begin
            errors++;
            $display("FAIL store_ack: got lat=%0d err=%b rdata=%h dbl=%b want 2 0 0 0",
                     lat, er, rd, dbl);
        end
        bus_txn(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'hCAFE_F00D || dbl !== 1'b0) begin
            errors++; $display("FAIL store_load_data: got %h dbl=%b want cafef00d 0", rd, dbl);
        end
        checks++;
        if (rd1 !== 16'd1 || wr1 !== 16'd1) begin
            errors++; $display("FAIL store_load_counts: got rd=%0d wr=%0d want 1 1", rd1, wr1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic dbl;
        bus_txn(1'b0, 32'h42, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misaligned_load: got lat=%0d err=%b rdata=%h want 2 1 0",
                               lat, er, rd);
        end
        bus_txn(1'b0, 32'h4000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL range_store: got lat=%0d err=%b rdata=%h want 2 1 0",
                               lat, er, rd);
        end
        checks++;
        if (rd1 !== 16'd1 || wr1 !== 16'd1) begin
            errors++; $display("FAIL error_counts: got rd=%0d wr=%0d want 1 1", rd1, wr1);
        end
        bus_txn(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h0010_0093 || er !== 1'b0) begin
            errors++; $display("FAIL error_no_write_w0: got %h err=%b want 00100093 0", rd, er);
        end
        bus_txn(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL error_no_write_w16: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_latency4();
        logic [31:0] rd; logic er; int lat; logic dbl;
        preload(12'd7, 32'hA5A5_0007);
        preload(12'd8, 32'h5A5A_0008);
        bus_txn(1'b1, 32'h1C, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (lat !== 5 || dbl !== 1'b0) begin
            errors++; $display("FAIL lat4_timing: got lat=%0d dbl=%b want 5 0", lat, dbl);
        end
        checks++;
        if (rd !== 32'hA5A5_0007 || er !== 1'b0) begin
            errors++; $display("FAIL lat4_data: got %h err=%b want a5a50007 0", rd, er);
        end
        checks++;
        if (rd4 !== 16'd1 || wr4 !== 16'd0) begin
            errors++; $display("FAIL lat4_counts: got rd=%0d wr=%0d want 1 0", rd4, wr4);
        end
        bus_txn(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h5A5A_0008) begin
            errors++; $display("FAIL lat4_toggle_ignored: got %h want 5a5a0008", rd);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd; logic er; int lat; logic dbl;
        bus_txn(1'b0, 32'h14, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 12'd5, 32'h1111_1111,
                rd, er, lat, dbl);
        bus_txn(1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h2222_2222) begin
            errors++; $display("FAIL coll_bus_wins: got %h want 22222222", rd);
        end
        preload(12'd6, 32'h6666_6666);
        bus_txn(1'b0, 32'h18, 1'b0, 32'h0, 1'b0, 1'b1, 12'd6, 32'h7777_7777, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h6666_6666) begin
            errors++; $display("FAIL coll_read_old: got %h want 66666666", rd);
        end
        bus_txn(1'b0, 32'h18, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h7777_7777) begin
            errors++; $display("FAIL coll_read_new: got %h want 77777777", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic dbl;
        preload(12'd9, 32'h0909_0909);
        use4 = 1'b0;
        @(posedge clk);
        #1;
        bus_addr  = 32'h24;
        bus_we    = 1'b1;
        bus_wdata = 32'hBAD0_BAD0;
        bus_req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b want 1", busy1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack1, err1, busy1, rdata1, rd1, wr1} !== 67'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got ack=%b err=%b busy=%b rdata=%h rd=%0d wr=%0d, want all 0",
                     ack1, err1, busy1, rdata1, rd1, wr1);
        end
        bus_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || ack1 !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got busy=%b ack=%b want 0 0", busy1, ack1);
        end
        bus_txn(1'b0, 32'h24, 1'b0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, rd, er, lat, dbl);
        checks++;
        if (rd !== 32'h0909_0909 || rd1 !== 16'd1 || wr1 !== 16'd0) begin
            errors++; $display("FAIL midrst_old_data: got %h rd=%0d wr=%0d want 09090909 1 0",
                               rd, rd1, wr1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        use4      = 1'b0;
        load_we   = 1'b0;
        load_addr = 12'd0;
        load_data = 32'h0;
        test_reset();
        test_read_basic();
        test_store_load();
        test_errors();
        test_latency4();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
Word-addressed memory target for the CPU's req/ack memory bus: it answers the CPU's fetch, load and store requests. It accepts one request at a time, applies a programmable access latency, and returns a single-cycle mem_ack with read data or an error flag. A side-band preload port lets the loader or testbench fill program and data images. It also keeps saturating access counters for debug.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
AW, $clog2(DEPTH_WORDS), word-index width.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
LATENCY, 1, cycles from request acceptance to mem_ack; legal range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
mem_addr  in  32  byte address from initiator
mem_wdata  in  32  store data
mem_req  in  1  request; held high by initiator until ack seen
mem_we  in  1  1 = store, 0 = load/fetch
mem_rdata  out  32  read data, valid only while mem_ack=1
mem_ack  out  1  one-cycle completion pulse
mem_err  out  1  qualifies mem_ack: out-of-range or misaligned access
busy  out  1  high in ACCESS and RESP states
load_we  in  1  preload write strobe
load_addr  in  AW  preload word index
load_data  in  32  preload data
rd_count  out  16  completed good reads, saturating at 16'hFFFF
wr_count  out  16  completed good writes, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE; mem_ack=0, mem_err=0, mem_rdata=0, busy=0, rd_count=0, wr_count=0, latency counter=0. The memory array is not reset.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, mem_req=1 at a clock edge: latch addr, we and wdata, and decode the access.
  - good = (addr[1:0]==0) and (BASE_ADDR <= addr < BASE_ADDR+DEPTH_WORDS*4).
  - Word index = (addr-BASE_ADDR)[AW+1:2].
  - Load cnt = LATENCY-1; go to ACCESS.
- ACCESS: if cnt != 0, decrement cnt. If cnt == 0, at that edge:
  - good read: register array[idx] into mem_rdata.
  - good write: commit wdata to array[idx]; mem_rdata=0.
  - error: no array write; mem_rdata=0; mem_err=1.
  - Set mem_ack=1 and go to RESP.
- Latency: with LATENCY=L and acceptance at edge E0, mem_ack is high in the cycle following edge E0+L. L=1 gives ack 2 cycles after the first req-high cycle.
- RESP: lasts exactly one cycle. At its end, clear mem_ack, mem_err and mem_rdata, then go to IDLE. Bump rd_count or wr_count at this edge on good accesses only.
- Bus inputs are ignored outside IDLE; changes to addr, wdata or we mid-transaction have no effect.
- Back-to-back requests: req still high in the first IDLE cycle after RESP is treated as a new request. The initiator drops req on the edge at which it samples ack, so no duplicate is generated.
- Preload: load_we=1 writes load_data to array[load_addr] at that edge in any state.
  - Collision: preload and a bus write commit to the same word at the same edge -> the bus write wins.
  - A bus read committing at the same edge as a preload write to the same word returns the old contents (read-before-write).
- Reads return data committed at any earlier edge.
- Reset asserted mid-transaction: the transaction is aborted; no ack and no counter update. A store whose commit edge had not yet occurred is not written.
- Counters hold at 16'hFFFF; they do not wrap.

Decomposition:
- Package unified_mem_pkg:
  - typedef mem_state_t (IDLE, ACCESS, RESP);
  - localparams for the alignment mask and the error read value 32'h0.
- Sub-module mem_word_array:
  - DEPTH_WORDS x 32 storage;
  - one synchronous read/write port (bus);
  - one write-only port (preload);
  - bus-write-priority and read-before-write rules implemented inside it.

Test Plan:
1. Preload word 0 = 32'h0010_0093. Bus read addr 0, LATENCY=1 -> mem_ack one cycle, 2 cycles after req rises; mem_rdata=32'h0010_0093; mem_err=0; rd_count=1.
2. Store 32'hCAFE_F00D to addr 32'h40, then load 32'h40 -> load returns 32'hCAFE_F00D; wr_count=1, rd_count=1; mem_ack is never high for 2 consecutive cycles.
3. Misaligned load 32'h42, then store to 32'h0000_4000 (DEPTH 4096) -> both ack with mem_err=1 and rdata=0; the array is unchanged; counters do not move.
4. LATENCY=4, req held high, addr toggled mid-ACCESS -> ack in the cycle after edge E0+4; data comes from the originally latched address.
5. Preload word 5 = 32'h1111_1111 at the same edge as a bus store of 32'h2222_2222 to addr 32'h14 -> a subsequent read returns 32'h2222_2222.
6. rst_n pulsed low while in ACCESS on a store, then a read of the same address -> old data returned; all outputs are 0 during reset; the FSM is in IDLE after release.
